csr_file: RTL and testbench
===========================

# csr_file

Architectural control/status register file for the LoongArch pipeline. It sits at the receiving end of the write-back stage's CSR/exception interface. It does the following:
- commits CSR writes from csrwr/csrxchg;
- records exception state on `wb_ex`;
- restores state on `ertn_flush`;
- runs the stable timer;
- returns the exception entry and return PCs to fetch.

It also provides the combinational CSR read port used by write-back.

## Interface
Parameters:
- TIMER_W, 32, width of TVAL/TCFG.InitVal+2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- csr_num  in  14  CSR address for read and write
- csr_rd_value  out  32  read data for csr_num; 0 for unmapped numbers
- csr_we  in  1  commit masked write this cycle
- csr_wvalue  in  32  write data
- csr_wmask  in  32  bit-enable; new = (old & ~mask) | (wvalue & mask), restricted to writable fields
- wb_ex  in  1  exception commit
- wb_ecode  in  6  exception code
- wb_subecode  in  9  exception subcode
- wb_pc  in  32  PC of the excepting instruction
- wb_badv  in  32  faulting virtual address
- ertn_flush  in  1  ertn commit
- hw_int_in  in  8  hardware interrupt lines (level)
- ipi_int_in  in  1  inter-processor interrupt (level)
- ex_entry  out  32  EENTRY value
- ertn_pc  out  32  ERA value
- has_int  out  1  interrupt pending and enabled

## Operation
Registers implemented (number: fields / writable bits / reset value):
- CRMD 0x00: PLV[1:0], IE[2], DA[3], PG[4]. Writable [4:0]. Reset 0x0000_0008.
- PRMD 0x01: PPLV[1:0], PIE[2]. Writable [2:0]. Reset 0.
- ECFG 0x04: LIE[12:0]. Writable mask 0x1BFF (bit 10 reserved). Reset 0.
- ESTAT 0x05: IS[12:0], Ecode[21:16], EsubCode[30:22]. Only IS[1:0] are CSR-writable. Reset 0.
- ERA 0x06, BADV 0x07, SAVE0–3 0x30–0x33, TID 0x40: all 32-bit, fully writable (BADV included). Reset 0.
- EENTRY 0x0C: VA[31:6] writable, [5:0] read 0. Reset 0.
- TCFG 0x41: En[0], Periodic[1], InitVal[31:2]. Fully writable. Reset 0.
- TVAL 0x42: read-only counter. Reset 0.
- TICLR 0x44: reads 0. A write with wvalue[0]&wmask[0] clears IS[11].

Exception commit (wb_ex=1):
- PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE
- CRMD.PLV<=0; CRMD.IE<=0
- ERA<=wb_pc
- ESTAT.Ecode/EsubCode<=wb_ecode/wb_subecode
- BADV<=wb_badv only for ecode 0x08 (ADE) or 0x09 (ALE); otherwise BADV is unchanged.

ertn commit (ertn_flush=1): CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PIE.

Interrupt status:
- IS[9:2]<=hw_int_in and IS[12]<=ipi_int_in every cycle (no reset masking beyond reset).
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).

Timer:
- A TCFG write loads TVAL<={new InitVal,2'b00}.
- Otherwise, if En and TVAL!=0, TVAL decrements by 1.
- On the cycle TVAL==1 and En:
  - set IS[11];
  - TVAL<= Periodic ? {InitVal,2'b00} : 0.
- En=1 with TVAL==0: TVAL holds and no new interrupt fires.

Priorities within one cycle:
- wb_ex > ertn_flush > csr_we. A write is dropped if either of the other two is asserted.
- Timer IS[11] set beats a TICLR clear in the same cycle.
- A TCFG write reload beats decrement/reload.
- A CSR write to ESTAT never touches IS[12:2], Ecode, or EsubCode.

## Timing
- Reads are combinational from current state, zero latency. A write is visible to reads on the next cycle (no bypass).
- ex_entry, ertn_pc, and has_int are combinational from registers. Outputs reflect a commit one cycle after it.
- hw_int_in/ipi_int_in reach has_int 1 cycle after assertion.
- Asynchronous reset, at any time, forces all registers to their reset values. Timer and interrupt state are lost.
- Reset output values:
  - csr_rd_value: 0x8 if csr_num=0, else 0
  - ex_entry=0
  - ertn_pc=0
  - has_int=0

## Structure
- Shared package holds:
  - CSR number constants (CSR_CRMD … CSR_TICLR);
  - ecode constants (ECODE_ADE=0x08, ECODE_ALE=0x09, etc.);
  - field bit-position constants (IS timer bit 11, IPI bit 12, LIE writable mask 0x1BFF).
- One sub-module, csr_timer, owns TCFG, TVAL, and the IS[11] set/clear logic. csr_file instantiates it and muxes its read data.

## Test plan
- **Reset:** reset=1 mid-run, then released → CRMD reads 0x8; ESTAT, ERA, TVAL read 0; has_int=0.
- **Masked write:** write SAVE0 wvalue=0xFFFF_FFFF mask=0x0000_FF00 over 0x1234_5678 → reads 0x1234_FF78. Write EENTRY 0x1C00_803F → reads 0x1C00_8000.
- **Exception then ertn:**
  - Setup: CRMD=0x7 (PLV3, IE1).
  - Exception: wb_ex with ecode 0x09, pc 0x1C00_0100, badv 0xDEAD_BEE1 → CRMD=0x0, PRMD=0x7, ERA=0x1C00_0100, BADV=0xDEAD_BEE1, ESTAT[21:16]=0x09.
  - Then ertn_flush → CRMD=0x7.
- **Exception with concurrent write:** wb_ex and csr_we to SAVE1 in the same cycle → SAVE1 unchanged. Ecode 0x0B (SYS) leaves BADV unchanged.
- **Timer:**
  - Configure TCFG=0x0000_000F (InitVal=3, periodic, En) → TVAL reads 12, then counts down.
  - IS[11] is set on the cycle TVAL goes 1→12.
  - With LIE[11]=1, IE=1 → has_int=1.
  - TICLR write 1 → IS[11]=0.
- **One-shot timer:** TCFG=0x0000_0005 → TVAL reaches 0 and holds; IS[11] sets exactly once. TICLR coinciding with the firing cycle leaves IS[11]=1.

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared constants and types for the LoongArch CSR file: CSR numbers, exception codes,
// interrupt-status bit positions and the masked-write merge helper.
package csr_file_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;

    localparam int          IS_HW_LSB  = 2;
    localparam int          IS_TI_BIT  = 11;
    localparam int          IS_IPI_BIT = 12;
    localparam logic [12:0] LIE_WMASK  = 13'h1BFF;

    typedef struct packed {
        logic       pg;
        logic       da;
        logic       ie;
        logic [1:0] plv;
    } crmd_t;

    typedef struct packed {
        logic       pie;
        logic [1:0] pplv;
    } prmd_t;

    localparam crmd_t CRMD_RST = '{pg: 1'b0, da: 1'b1, ie: 1'b0, plv: 2'd0};

    function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                                 input logic [31:0] wvalue,
                                                 input logic [31:0] wmask);
        return (old_val & ~wmask) | (wvalue & wmask);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// Stable timer: owns TCFG and TVAL and the timer interrupt flag (ESTAT.IS[11]),
// including its TICLR clear.
module csr_timer
    import csr_file_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en_i,
    input  logic [13:0]        csr_num_i,
    input  logic [31:0]        wvalue_i,
    input  logic [31:0]        wmask_i,
    output logic [31:0]        tcfg_o,
    output logic [TIMER_W-1:0] tval_o,
    output logic               ti_o
);

    localparam logic [TIMER_W-1:0] TVAL_ONE = TIMER_W'(1);

    logic [31:0]        tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;
    logic [TIMER_W-1:0] reload;
    logic               ti_q, ti_d;
    logic               tcfg_wr, ticlr_wr, fire;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        tcfg_wr  = wr_en_i && (csr_num_i == CSR_TCFG);
        ticlr_wr = wr_en_i && (csr_num_i == CSR_TICLR) && wvalue_i[0] && wmask_i[0];
        tcfg_d   = tcfg_wr ? masked_write(tcfg_q, wvalue_i, wmask_i) : tcfg_q;
        reload   = {tcfg_d[TIMER_W-1:2], 2'b00};
        fire     = 1'b0;
        tval_d   = tval_q;

        // A TCFG write restarts the count and suppresses this cycle's expiry.
        if (tcfg_wr) begin
            tval_d = reload;
        end else if (tcfg_q[0] && (tval_q != '0)) begin
            if (tval_q == TVAL_ONE) begin
                fire   = 1'b1;
                tval_d = tcfg_q[1] ? reload : '0;
            end else begin
                tval_d = tval_q - TVAL_ONE;
            end
        end

        ti_d = ti_q;
        if (ticlr_wr) ti_d = 1'b0;
        if (fire)     ti_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcfg_q <= '0;
            tval_q <= '0;
            ti_q   <= 1'b0;
        end else begin
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            ti_q   <= ti_d;
        end
    end

    assign tcfg_o = tcfg_q;
    assign tval_o = tval_q;
    assign ti_o   = ti_q;

endmodule

// File: rtl/csr_file.sv
// Architectural CSR file: masked CSR writes, exception/ertn state save and restore,
// interrupt status sampling and the combinational read port.
module csr_file
    import csr_file_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rd_value,
    input  logic        csr_we,
    input  logic [31:0] csr_wvalue,
    input  logic [31:0] csr_wmask,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_subecode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_badv,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_pc,
    output logic        has_int
);

    crmd_t        crmd_q, crmd_d;
    prmd_t        prmd_q, prmd_d;
    logic [12:0]  lie_q, lie_d;
    logic [1:0]   is_sw_q, is_sw_d;
    logic [7:0]   is_hw_q;
    logic         is_ipi_q;
    logic [5:0]   ecode_q, ecode_d;
    logic [8:0]   esub_q, esub_d;
    logic [31:0]  era_q, era_d;
    logic [31:0]  badv_q, badv_d;
    logic [25:0]  eentry_q, eentry_d;
    logic [31:0]  tid_q, tid_d;
    logic [31:0]  save_q [4];
    logic [31:0]  save_d [4];

    logic [31:0]        tcfg;
    logic [TIMER_W-1:0] tval;
    logic               ti;
    logic               csr_wr_en;
    logic [12:0]        is_all;
    logic [31:0]        wr_merged;

    assign csr_wr_en = csr_we && !wb_ex && !ertn_flush;

    csr_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (csr_wr_en),
        .csr_num_i (csr_num),
        .wvalue_i  (csr_wvalue),
        .wmask_i   (csr_wmask),
        .tcfg_o    (tcfg),
        .tval_o    (tval),
        .ti_o      (ti)
    );

    always_comb begin
        is_all                      = '0;
        is_all[1:0]                 = is_sw_q;
        is_all[IS_HW_LSB +: 8]      = is_hw_q;
        is_all[IS_TI_BIT]           = ti;
        is_all[IS_IPI_BIT]          = is_ipi_q;
    end

    always_comb begin
        csr_rd_value = '0;
        case (csr_num)
            CSR_CRMD:   csr_rd_value = {27'b0, crmd_q};
            CSR_PRMD:   csr_rd_value = {29'b0, prmd_q};
            CSR_ECFG:   csr_rd_value = {19'b0, lie_q};
            CSR_ESTAT:  csr_rd_value = {1'b0, esub_q, ecode_q, 3'b000, is_all};
            CSR_ERA:    csr_rd_value = era_q;
            CSR_BADV:   csr_rd_value = badv_q;
            CSR_EENTRY: csr_rd_value = {eentry_q, 6'b0};
            CSR_SAVE0:  csr_rd_value = save_q[0];
            CSR_SAVE1:  csr_rd_value = save_q[1];
            CSR_SAVE2:  csr_rd_value = save_q[2];
            CSR_SAVE3:  csr_rd_value = save_q[3];
            CSR_TID:    csr_rd_value = tid_q;
            CSR_TCFG:   csr_rd_value = tcfg;
            CSR_TVAL:   csr_rd_value = 32'(tval);
            default:    csr_rd_value = '0;
        endcase
    end

    // Merging against the read value lets each register simply keep its writable slice.
    assign wr_merged = masked_write(csr_rd_value, csr_wvalue, csr_wmask);

    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        lie_d    = lie_q;
        is_sw_d  = is_sw_q;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        tid_d    = tid_q;
        save_d   = save_q;

        if (wb_ex) begin
            prmd_d.pplv = crmd_q.plv;
            prmd_d.pie  = crmd_q.ie;
            crmd_d.plv  = 2'd0;
            crmd_d.ie   = 1'b0;
            era_d       = wb_pc;
            ecode_d     = wb_ecode;
            esub_d      = wb_subecode;
            if ((wb_ecode == ECODE_ADE) || (wb_ecode == ECODE_ALE)) badv_d = wb_badv;
        end else if (ertn_flush) begin
            crmd_d.plv = prmd_q.pplv;
            crmd_d.ie  = prmd_q.pie;
        end else if (csr_we) begin
            case (csr_num)
                CSR_CRMD:   crmd_d   = crmd_t'(wr_merged[4:0]);
                CSR_PRMD:   prmd_d   = prmd_t'(wr_merged[2:0]);
                CSR_ECFG:   lie_d    = wr_merged[12:0] & LIE_WMASK;
                CSR_ESTAT:  is_sw_d  = wr_merged[1:0];
                CSR_ERA:    era_d    = wr_merged;
                CSR_BADV:   badv_d   = wr_merged;
                CSR_EENTRY: eentry_d = wr_merged[31:6];
                CSR_SAVE0:  save_d[0] = wr_merged;
                CSR_SAVE1:  save_d[1] = wr_merged;
                CSR_SAVE2:  save_d[2] = wr_merged;
                CSR_SAVE3:  save_d[3] = wr_merged;
                CSR_TID:    tid_d    = wr_merged;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crmd_q   <= CRMD_RST;
            prmd_q   <= '0;
            lie_q    <= '0;
            is_sw_q  <= '0;
            is_hw_q  <= '0;
            is_ipi_q <= 1'b0;
            ecode_q  <= '0;
            esub_q   <= '0;
            era_q    <= '0;
            badv_q   <= '0;
            eentry_q <= '0;
            tid_q    <= '0;
            // NOTE: SAVE0-3 are architectural flops with a defined reset value, not a RAM, so they are reset.
            for (int i = 0; i < 4; i++) save_q[i] <= '0;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            lie_q    <= lie_d;
            is_sw_q  <= is_sw_d;
            is_hw_q  <= hw_int_in;
            is_ipi_q <= ipi_int_in;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            tid_q    <= tid_d;
            save_q   <= save_d;
        end
    end

    assign ex_entry = {eentry_q, 6'b0};
    assign ertn_pc  = era_q;
    assign has_int  = crmd_q.ie && |(is_all & lie_q);

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic against
// a CSR-number-indexed reference model.
`timescale 1ns/1ps
module tb_csr_file;
    import csr_file_pkg::*;

    logic        clk;
    logic        reset;
    logic [13:0] csr_num;
    logic [31:0] csr_rd_value;
    logic        csr_we;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_wmask;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_subecode;
    logic [31:0] wb_pc;
    logic [31:0] wb_badv;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_pc;
    logic        has_int;

    int checks = 0;
    int errors = 0;

    csr_file #(.TIMER_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .csr_num      (csr_num),
        .csr_rd_value (csr_rd_value),
        .csr_we       (csr_we),
        .csr_wvalue   (csr_wvalue),
        .csr_wmask    (csr_wmask),
        .wb_ex        (wb_ex),
        .wb_ecode     (wb_ecode),
        .wb_subecode  (wb_subecode),
        .wb_pc        (wb_pc),
        .wb_badv      (wb_badv),
        .ertn_flush   (ertn_flush),
        .hw_int_in    (hw_int_in),
        .ipi_int_in   (ipi_int_in),
        .ex_entry     (ex_entry),
        .ertn_pc      (ertn_pc),
        .has_int      (has_int)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Reference model: architectural register contents indexed by CSR number.
    logic [31:0] m [0:127];

    logic [13:0] nums [18] = '{CSR_CRMD, CSR_PRMD, CSR_ECFG, CSR_ESTAT, CSR_ERA, CSR_BADV,
                               CSR_EENTRY, CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3, CSR_TID,
                               CSR_TCFG, CSR_TVAL, CSR_TICLR, 14'h002, 14'h020, 14'h3FFF};

    function automatic logic [6:0] ix(input logic [13:0] n);
        return n[6:0];
    endfunction

    function automatic logic [31:0] wmask_of(input logic [13:0] n);
        case (n)
            CSR_CRMD:   return 32'h0000_001F;
            CSR_PRMD:   return 32'h0000_0007;
            CSR_ECFG:   return 32'h0000_1BFF;
            CSR_ESTAT:  return 32'h0000_0003;
            CSR_EENTRY: return 32'hFFFF_FFC0;
            CSR_ERA, CSR_BADV, CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3,
            CSR_TID, CSR_TCFG: return 32'hFFFF_FFFF;
            default:    return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] n);
        case (n)
            CSR_CRMD, CSR_PRMD, CSR_ECFG, CSR_ESTAT, CSR_ERA, CSR_BADV, CSR_EENTRY,
            CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3, CSR_TID, CSR_TCFG,
            CSR_TVAL: return m[ix(n)];
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic model_has_int();
        return m[ix(CSR_CRMD)][2] && ((m[ix(CSR_ESTAT)][12:0] & m[ix(CSR_ECFG)][12:0]) != 13'h0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m[i] = 32'h0;
        m[ix(CSR_CRMD)] = 32'h8;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        logic [31:0] nm [0:127];
        logic [31:0] wm, cfg, tv;
        logic        we, fire;
        nm = m;
        we = csr_we && !wb_ex && !ertn_flush;
        if (wb_ex) begin
            nm[ix(CSR_PRMD)] = {29'b0, m[ix(CSR_CRMD)][2:0]};
            nm[ix(CSR_CRMD)] = m[ix(CSR_CRMD)] & ~32'h7;
            nm[ix(CSR_ERA)]  = wb_pc;
            nm[ix(CSR_ESTAT)][30:16] = {wb_subecode, wb_ecode};
            if (wb_ecode == ECODE_ADE || wb_ecode == ECODE_ALE) nm[ix(CSR_BADV)] = wb_badv;
        end else if (ertn_flush) begin
            nm[ix(CSR_CRMD)] = (m[ix(CSR_CRMD)] & ~32'h7) | (m[ix(CSR_PRMD)] & 32'h7);
        end else if (we) begin
            wm = wmask_of(csr_num);
            if (wm != 32'h0)
                nm[ix(csr_num)] = (m[ix(csr_num)] & ~(csr_wmask & wm)) | (csr_wvalue & csr_wmask & wm);
        end
        nm[ix(CSR_ESTAT)][9:2] = hw_int_in;
        nm[ix(CSR_ESTAT)][12]  = ipi_int_in;
        cfg  = m[ix(CSR_TCFG)];
        tv   = m[ix(CSR_TVAL)];
        fire = 1'b0;
        if (we && csr_num == CSR_TCFG) begin
            nm[ix(CSR_TVAL)] = nm[ix(CSR_TCFG)] & ~32'h3;
        end else if (cfg[0] && tv == 32'd1) begin
            fire = 1'b1;
            nm[ix(CSR_TVAL)] = cfg[1] ? (cfg & ~32'h3) : 32'h0;
        end else if (cfg[0] && tv != 32'd0) begin
            nm[ix(CSR_TVAL)] = tv - 32'd1;
        end
        if (we && csr_num == CSR_TICLR && csr_wvalue[0] && csr_wmask[0]) nm[ix(CSR_ESTAT)][11] = 1'b0;
        if (fire) nm[ix(CSR_ESTAT)][11] = 1'b1;
        m = nm;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        csr_we     = 1'b0;
        wb_ex      = 1'b0;
        ertn_flush = 1'b0;
    endtask

    task automatic csr_write(input logic [13:0] n, input logic [31:0] v, input logic [31:0] mk);
        csr_num    = n;
        csr_wvalue = v;
        csr_wmask  = mk;
        csr_we     = 1'b1;
        step();
    endtask

    task automatic rd(input logic [13:0] n, output logic [31:0] v);
        csr_num = n;
        #1;
        v = csr_rd_value;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        csr_write(CSR_ERA, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        csr_write(CSR_TCFG, 32'h0000_0101, 32'hFFFF_FFFF);
        csr_write(CSR_CRMD, 32'h7, 32'hFFFF_FFFF);
        csr_write(CSR_ECFG, 32'h1BFF, 32'hFFFF_FFFF);
        csr_write(CSR_ESTAT, 32'h3, 32'hFFFF_FFFF);
        checks++; if (has_int !== 1'b1) begin errors++; $display("FAIL pre_reset_has_int: got %b want 1", has_int); end
        #20 reset = 1'b1;
        #10;
        checks++; if (ertn_pc !== 32'h0 || has_int !== 1'b0) begin
            errors++; $display("FAIL reset_async: ertn_pc=%h has_int=%b want 0/0", ertn_pc, has_int); end
        @(posedge clk);
        #30 reset = 1'b0;
        model_reset();
        rd(CSR_CRMD, v);
        checks++; if (v !== 32'h8) begin errors++; $display("FAIL reset_crmd: got %h want %h", v, 32'h8); end
        rd(CSR_ESTAT, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_estat: got %h want 0", v); end
        rd(CSR_ERA, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_era: got %h want 0", v); end
        rd(CSR_TVAL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_tval: got %h want 0", v); end
        checks++; if (has_int !== 1'b0 || ex_entry !== 32'h0 || ertn_pc !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: has_int=%b ex_entry=%h ertn_pc=%h want 0", has_int, ex_entry, ertn_pc); end
        step();
    endtask

    task automatic test_masked_write();
        logic [31:0] v;
        csr_write(CSR_SAVE0, 32'h1234_5678, 32'hFFFF_FFFF);
        csr_num = CSR_SAVE0; csr_wvalue = 32'hFFFF_FFFF; csr_wmask = 32'h0000_FF00; csr_we = 1'b1;
        #1;
        checks++; if (csr_rd_value !== 32'h1234_5678) begin
            errors++; $display("FAIL no_bypass: got %h want %h", csr_rd_value, 32'h1234_5678); end
        step();
        rd(CSR_SAVE0, v);
        checks++; if (v !== 32'h1234_FF78) begin errors++; $display("FAIL save0_masked: got %h want %h", v, 32'h1234_FF78); end
        csr_write(CSR_EENTRY, 32'h1C00_803F, 32'hFFFF_FFFF);
        rd(CSR_EENTRY, v);
        checks++; if (v !== 32'h1C00_8000) begin errors++; $display("FAIL eentry_read: got %h want %h", v, 32'h1C00_8000); end
        checks++; if (ex_entry !== 32'h1C00_8000) begin errors++; $display("FAIL ex_entry: got %h want %h", ex_entry, 32'h1C00_8000); end
        csr_write(CSR_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(CSR_ECFG, v);
        checks++; if (v !== 32'h1BFF) begin errors++; $display("FAIL ecfg_mask: got %h want %h", v, 32'h1BFF); end
        csr_write(CSR_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(CSR_ESTAT, v);
        checks++; if (v !== 32'h3) begin errors++; $display("FAIL estat_sw_only: got %h want %h", v, 32'h3); end
        csr_write(CSR_ESTAT, 32'h0, 32'h3);
        csr_write(CSR_TVAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(CSR_TVAL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL tval_readonly: got %h want 0", v); end
        rd(14'h3FFF, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", v); end
    endtask

    task automatic test_exception_ertn();
        logic [31:0] v;
        csr_write(CSR_CRMD, 32'h7, 32'hFFFF_FFFF);
        rd(CSR_CRMD, v);
        checks++; if (v !== 32'h7) begin errors++; $display("FAIL crmd_setup: got %h want 7", v); end
        wb_ex = 1'b1; wb_ecode = ECODE_ALE; wb_subecode = 9'h0;
        wb_pc = 32'h1C00_0100; wb_badv = 32'hDEAD_BEE1;
        step();
        rd(CSR_CRMD, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL ex_crmd: got %h want 0", v); end
        rd(CSR_PRMD, v);
        checks++; if (v !== 32'h7) begin errors++; $display("FAIL ex_prmd: got %h want 7", v); end
        rd(CSR_ERA, v);
        checks++; if (v !== 32'h1C00_0100 || ertn_pc !== 32'h1C00_0100) begin
            errors++; $display("FAIL ex_era: got %h/%h want %h", v, ertn_pc, 32'h1C00_0100); end
        rd(CSR_BADV, v);
        checks++; if (v !== 32'hDEAD_BEE1) begin errors++; $display("FAIL ex_badv: got %h want %h", v, 32'hDEAD_BEE1); end
        rd(CSR_ESTAT, v);
        checks++; if (v[21:16] !== 6'h09) begin errors++; $display("FAIL ex_ecode: got %h want 09", v[21:16]); end
        ertn_flush = 1'b1;
        csr_num = CSR_SAVE2; csr_wvalue = 32'h5555_5555; csr_wmask = 32'hFFFF_FFFF; csr_we = 1'b1;
        step();
        rd(CSR_CRMD, v);
        checks++; if (v !== 32'h7) begin errors++; $display("FAIL ertn_crmd: got %h want 7", v); end
        rd(CSR_SAVE2, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL ertn_drops_write: got %h want 0", v); end
    endtask

    task automatic test_ex_concurrent_write();
        logic [31:0] v;
        csr_write(CSR_SAVE1, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        wb_ex = 1'b1; wb_ecode = ECODE_SYS; wb_subecode = 9'h155;
        wb_pc = 32'h1C00_0200; wb_badv = 32'h1111_1111;
        csr_num = CSR_SAVE1; csr_wvalue = 32'hFFFF_FFFF; csr_wmask = 32'hFFFF_FFFF; csr_we = 1'b1;
        step();
        rd(CSR_SAVE1, v);
        checks++; if (v !== 32'hA5A5_A5A5) begin errors++; $display("FAIL ex_drops_write: got %h want %h", v, 32'hA5A5_A5A5); end
        rd(CSR_BADV, v);
        checks++; if (v !== 32'hDEAD_BEE1) begin errors++; $display("FAIL sys_keeps_badv: got %h want %h", v, 32'hDEAD_BEE1); end
        rd(CSR_ESTAT, v);
        checks++; if (v !== 32'h554B_0000) begin errors++; $display("FAIL sys_estat: got %h want %h", v, 32'h554B_0000); end
        checks++; if (ertn_pc !== 32'h1C00_0200) begin errors++; $display("FAIL sys_era: got %h want %h", ertn_pc, 32'h1C00_0200); end
        ertn_flush = 1'b1;
        step();
    endtask

    task automatic test_timer_periodic();
        logic [31:0] v;
        csr_write(CSR_ECFG, 32'h800, 32'hFFFF_FFFF);
        csr_write(CSR_TCFG, 32'h0000_000F, 32'hFFFF_FFFF);
        rd(CSR_TVAL, v);
        checks++; if (v !== 32'd12) begin errors++; $display("FAIL tcfg_load: got %0d want 12", v); end
        for (int k = 1; k <= 11; k++) begin
            step();
            rd(CSR_TVAL, v);
            checks++; if (v !== 32'(12 - k)) begin errors++; $display("FAIL tval_count%0d: got %0d want %0d", k, v, 12 - k); end
            rd(CSR_ESTAT, v);
            checks++; if (v[IS_TI_BIT] !== 1'b0) begin errors++; $display("FAIL ti_early%0d: got 1 want 0", k); end
        end
        step();
        rd(CSR_TVAL, v);
        checks++; if (v !== 32'd12) begin errors++; $display("FAIL periodic_reload: got %0d want 12", v); end
        rd(CSR_ESTAT, v);
        checks++; if (v[IS_TI_BIT] !== 1'b1) begin errors++; $display("FAIL ti_set: got 0 want 1"); end
        checks++; if (has_int !== 1'b1) begin errors++; $display("FAIL timer_has_int: got %b want 1", has_int); end
        csr_write(CSR_TICLR, 32'h1, 32'h1);
        rd(CSR_ESTAT, v);
        checks++; if (v[IS_TI_BIT] !== 1'b0 || has_int !== 1'b0) begin
            errors++; $display("FAIL ticlr: is11=%b has_int=%b want 0/0", v[IS_TI_BIT], has_int); end
        rd(CSR_TVAL, v);
        checks++; if (v !== 32'd11) begin errors++; $display("FAIL tval_after_clr: got %0d want 11", v); end
        csr_write(CSR_TCFG, 32'h0, 32'hFFFF_FFFF);
    endtask

    task automatic test_timer_oneshot();
        logic [31:0] v;
        csr_write(CSR_TCFG, 32'h0000_0005, 32'hFFFF_FFFF);
        rd(CSR_TVAL, v);
        checks++; if (v !== 32'd4) begin errors++; $display("FAIL oneshot_load: got %0d want 4", v); end
        step(); step(); step();
        rd(CSR_TVAL, v);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL oneshot_at1: got %0d want 1", v); end
        csr_write(CSR_TICLR, 32'h1, 32'h1);
        rd(CSR_ESTAT, v);
        checks++; if (v[IS_TI_BIT] !== 1'b1) begin errors++; $display("FAIL set_beats_clear: got 0 want 1"); end
        rd(CSR_TVAL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL oneshot_zero: got %0d want 0", v); end
        csr_write(CSR_TICLR, 32'h1, 32'h1);
        for (int k = 0; k < 6; k++) begin
            step();
            rd(CSR_TVAL, v);
            checks++; if (v !== 32'h0) begin errors++; $display("FAIL oneshot_hold%0d: got %0d want 0", k, v); end
            rd(CSR_ESTAT, v);
            checks++; if (v[IS_TI_BIT] !== 1'b0) begin errors++; $display("FAIL oneshot_refire%0d: got 1 want 0", k); end
        end
        csr_write(CSR_TCFG, 32'h0, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        logic [31:0] v, exp_v;
        logic [13:0] n;
        for (int it = 0; it < 400; it++) begin
            n          = nums[$urandom_range(0, 17)];
            csr_num    = n;
            csr_we     = ($urandom_range(0, 2) == 0);
            csr_wvalue = (n == CSR_TCFG) ? 32'($urandom_range(0, 63)) : $urandom;
            csr_wmask  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            wb_ex      = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 4))
                0: wb_ecode = ECODE_ADE;
                1: wb_ecode = ECODE_ALE;
                2: wb_ecode = ECODE_SYS;
                3: wb_ecode = ECODE_BRK;
                default: wb_ecode = 6'($urandom);
            endcase
            wb_subecode = 9'($urandom);
            wb_pc       = $urandom;
            wb_badv     = $urandom;
            ertn_flush  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) hw_int_in = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ipi_int_in = 1'($urandom);
            step();
            n = nums[$urandom_range(0, 17)];
            rd(n, v);
            exp_v = model_read(n);
            checks++; if (v !== exp_v) begin errors++; $display("FAIL rand_read[%0d] csr %h: got %h want %h", it, n, v, exp_v); end
            checks++; if (ex_entry !== m[ix(CSR_EENTRY)] || ertn_pc !== m[ix(CSR_ERA)]) begin
                errors++; $display("FAIL rand_pcs[%0d]: got %h/%h want %h/%h", it, ex_entry, ertn_pc, m[ix(CSR_EENTRY)], m[ix(CSR_ERA)]); end
            checks++; if (has_int !== model_has_int()) begin
                errors++; $display("FAIL rand_has_int[%0d]: got %b want %b", it, has_int, model_has_int()); end
        end
        hw_int_in  = 8'h0;
        ipi_int_in = 1'b0;
        step();
    endtask

    initial begin
        reset       = 1'b1;
        csr_num     = '0;
        csr_we      = 1'b0;
        csr_wvalue  = '0;
        csr_wmask   = '0;
        wb_ex       = 1'b0;
        wb_ecode    = ECODE_INT;
        wb_subecode = '0;
        wb_pc       = '0;
        wb_badv     = '0;
        ertn_flush  = 1'b0;
        hw_int_in   = '0;
        ipi_int_in  = 1'b0;
        model_reset();
        #130 reset = 1'b0;

        test_reset();
        test_masked_write();
        test_exception_ertn();
        test_ex_concurrent_write();
        test_timer_periodic();
        test_timer_oneshot();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
